// File: rtl/sipo_deser_frame.sv
// Serial-to-parallel deserializer with bit counter, one-word holding
// register, valid/ready handshake and sticky overrun flag.
module sipo_deser_frame #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       bit_valid,
  input  logic                       bit_in,
  output logic [WIDTH-1:0]           data_out,
  output logic                       data_valid,
  input  logic                       data_ready,
  output logic                       overrun,
  output logic [$clog2(WIDTH+1)-1:0] bit_count
);

  localparam int CW = $clog2(WIDTH+1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH-1);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] word;
  logic             take;
  logic             complete;

  // Word including the bit arriving on this edge.
  always_comb begin
    word = {sh[WIDTH-2:0], bit_in};
    if (!MSB_FIRST) begin
      word = {bit_in, sh[WIDTH-1:1]};
    end
  end

  assign take       = bit_valid && !clear;
  assign complete   = take && (bit_count == LAST);
  assign data_valid = (state == FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh        <= '0;
      bit_count <= '0;
    end else if (clear) begin
      sh        <= '0;
      bit_count <= '0;
    end else if (take) begin
      sh        <= word;
      bit_count <= complete ? '0 : bit_count + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      data_out <= '0;
    end else begin
      unique case (1'b1)
        (state == EMPTY): begin
          if (complete) begin
            state    <= FULL;
            data_out <= word;
          end
        end
        (state == FULL): begin
          if (complete && data_ready) begin
            data_out <= word;
          end else if (data_ready) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // Drop happens only when a word completes into an unconsumed slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (clear) begin
      overrun <= 1'b0;
    end else if (complete && data_valid && !data_ready) begin
      overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sipo_deser_frame.sv
// Bench for sipo_deser_frame: MSB-first and LSB-first instances share
// stimulus; consumed words are checked against a scoreboard queue.
module tb_sipo_deser_frame;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic       bit_valid;
  logic       bit_in;
  logic       data_ready;
  logic [7:0] dm, dl;
  logic       vm, vl, om, ol;
  logic [3:0] cm, cl;

  int checks = 0;
  int errors = 0;

  logic [7:0] q_m[$];
  logic [7:0] q_l[$];
  logic [7:0] em, el;

  typedef struct {
    logic [7:0] word;
    logic [7:0] exp_m;
    logic [7:0] exp_l;
  } vec_t;

  vec_t vt[8];

  always #5 clk = ~clk;

  sipo_deser_frame #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .bit_valid(bit_valid), .bit_in(bit_in),
    .data_out(dm), .data_valid(vm), .data_ready(data_ready),
    .overrun(om), .bit_count(cm)
  );

  sipo_deser_frame #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .bit_valid(bit_valid), .bit_in(bit_in),
    .data_out(dl), .data_valid(vl), .data_ready(data_ready),
    .overrun(ol), .bit_count(cl)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] m, input logic [7:0] l);
    q_m.push_back(m);
    q_l.push_back(l);
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) begin
      bit_valid = 1'b1;
      bit_in    = w[i];
      tick();
    end
    bit_valid = 1'b0;
  endtask

  // Handshake happens on the next rising edge; compare the word now.
  always @(negedge clk) begin
    if (rst_n && vm && data_ready) begin
      chk("valid_match", vl, vm);
      if (q_m.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word got %0h want none", dm);
      end else begin
        em = q_m.pop_front();
        el = q_l.pop_front();
        chk("word_msb", dm, em);
        chk("word_lsb", dl, el);
      end
    end
  end

  initial begin
    vt[0] = '{8'hA5, 8'hA5, 8'hA5};
    vt[1] = '{8'hC0, 8'hC0, 8'h03};
    vt[2] = '{8'h3C, 8'h3C, 8'h3C};
    vt[3] = '{8'h01, 8'h01, 8'h80};
    vt[4] = '{8'hF0, 8'hF0, 8'h0F};
    vt[5] = '{8'h81, 8'h81, 8'h81};
    vt[6] = '{8'hFF, 8'hFF, 8'hFF};
    vt[7] = '{8'h96, 8'h96, 8'h69};

    rst_n = 1'b0;
    clear = 1'b0;
    bit_valid = 1'b0;
    bit_in = 1'b0;
    data_ready = 1'b0;
    repeat (3) tick();
    chk("rst_data", dm, 8'h00);
    chk("rst_valid", vm, 1'b0);
    chk("rst_overrun", om, 1'b0);
    chk("rst_count", cm, 4'd0);
    chk("rst_data_lsb", dl, 8'h00);
    rst_n = 1'b1;
    tick();

    // Latency: valid right after the last-bit edge, for one cycle.
    data_ready = 1'b1;
    push(8'hA5, 8'hA5);
    for (int i = 7; i >= 1; i--) begin
      bit_valid = 1'b1;
      bit_in = vt[0].word[i];
      tick();
    end
    chk("lat_count7", cm, 4'd7);
    chk("lat_pre_valid", vm, 1'b0);
    bit_in = 1'b1;
    tick();
    bit_valid = 1'b0;
    chk("lat_valid", vm, 1'b1);
    chk("lat_count0", cm, 4'd0);
    tick();
    chk("lat_valid_drop", vm, 1'b0);

    for (int k = 0; k < 8; k++) begin
      push(vt[k].exp_m, vt[k].exp_l);
      send_word(vt[k].word);
      repeat (2) tick();
      chk("tbl_overrun", om, 1'b0);
      chk("tbl_valid", vm, 1'b0);
    end

    // Overrun: second word dropped, first kept.
    data_ready = 1'b0;
    push(8'h3C, 8'h3C);
    send_word(8'h3C);
    send_word(8'hFF);
    tick();
    chk("ovr_data", dm, 8'h3C);
    chk("ovr_valid", vm, 1'b1);
    chk("ovr_flag", om, 1'b1);
    chk("ovr_flag_lsb", ol, 1'b1);
    data_ready = 1'b1;
    tick();
    chk("ovr_consumed", vm, 1'b0);
    chk("ovr_sticky", om, 1'b1);
    data_ready = 1'b0;
    tick();
    chk("ovr_sticky2", om, 1'b1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("ovr_cleared", om, 1'b0);

    // Clear mid-word discards the partial word and the bit on that edge.
    data_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bit_valid = 1'b1;
      bit_in = 1'b1;
      tick();
    end
    bit_valid = 1'b0;
    chk("clr_count5", cm, 4'd5);
    clear = 1'b1;
    bit_valid = 1'b1;
    tick();
    clear = 1'b0;
    bit_valid = 1'b0;
    chk("clr_count0", cm, 4'd0);
    chk("clr_no_valid", vm, 1'b0);
    push(8'h81, 8'h81);
    send_word(8'h81);
    chk("clr_word", dm, 8'h81);
    tick();

    // Handshake and completion on the same edge: no overrun.
    data_ready = 1'b0;
    push(8'h11, 8'h88);
    push(8'h22, 8'h44);
    send_word(8'h11);
    tick();
    chk("same_hold", vm, 1'b1);
    for (int i = 7; i >= 1; i--) begin
      bit_valid = 1'b1;
      bit_in = ((8'h22 >> i) & 8'h01) != 0;
      tick();
    end
    bit_in = 1'b0;
    data_ready = 1'b1;
    tick();
    bit_valid = 1'b0;
    chk("same_valid", vm, 1'b1);
    chk("same_data", dm, 8'h22);
    chk("same_overrun", om, 1'b0);
    tick();
    chk("same_drain", vm, 1'b0);

    // Back-to-back words with bit_valid held high.
    data_ready = 1'b1;
    push(8'h00, 8'h00);
    push(8'hFF, 8'hFF);
    push(8'h5A, 8'h5A);
    push(8'hC3, 8'hC3);
    for (int w = 0; w < 4; w++) begin
      for (int i = 7; i >= 0; i--) begin
        bit_valid = 1'b1;
        case (w)
          0: bit_in = 1'b0;
          1: bit_in = 1'b1;
          2: bit_in = ((8'h5A >> i) & 8'h01) != 0;
          default: bit_in = ((8'hC3 >> i) & 8'h01) != 0;
        endcase
        tick();
      end
    end
    bit_valid = 1'b0;
    repeat (3) tick();
    chk("b2b_overrun", om, 1'b0);
    chk("b2b_drained", q_m.size(), 0);

    // Async reset mid-cycle while full, overrun and mid-word.
    data_ready = 1'b0;
    send_word(8'h5A);
    send_word(8'hFF);
    for (int i = 0; i < 3; i++) begin
      bit_valid = 1'b1;
      bit_in = 1'b1;
      tick();
    end
    bit_valid = 1'b0;
    chk("ar_pre_overrun", om, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", vm, 1'b0);
    chk("ar_data", dm, 8'h00);
    chk("ar_count", cm, 4'd0);
    chk("ar_overrun", om, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("ar_no_spurious", vm, 1'b0);
    chk("queue_empty", q_m.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
